nn_weight_loader: RTL and testbench
===================================

Name: nn_weight_loader

Overview:
- Writer-side counterpart of the first-layer weight store: receives a serial byte stream of 16-bit signed weights and writes them into an 8-entry × 4-weight register array.
- Exposes the same read shape as the fixed weight table: 3-bit address in, four signed 16-bit weights out. The MLP datapath can therefore use weights loaded at run time, e.g. streamed over the sensor/host link after power-up.

Parameters:
- NEURONS, 8, number of rows (hidden-layer neurons); address width is clog2(NEURONS).
- INPUTS, 4, weights per row (w1..w4); fixed at 4 by the port list, kept for package consistency.
- WIDTH, 16, weight width in bits (two bytes per weight).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  single-cycle pulse that begins a load
- s_valid  in  1  byte-stream valid
- s_data  in  8  byte-stream data
- s_ready  out  1  byte accepted when s_valid && s_ready
- busy  out  1  high while a load is in progress
- done  out  1  high after a complete, good load; sticky until the next start or rst
- err  out  1  checksum error, sticky; constant 0 when CHECKSUM_EN is not defined
- rd_addr  in  3  read row select
- w1, w2, w3, w4  out  16 signed  weights of row rd_addr

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All 32 weight registers clear to 0.
  - s_ready=0, busy=0, done=0, err=0.
  - Byte, word and row counters clear to 0.
- States and transitions:
  - IDLE: start moves to LOAD.
  - LOAD: after the 64th accepted byte, go to CHK if CHECKSUM_EN is defined, otherwise to DONE.
  - CHK: one accepted byte moves to DONE.
  - DONE: start moves to LOAD.
- start:
  - Sampled only in IDLE or DONE.
  - Ignored in LOAD and CHK; no restart, no counter change.
  - Entering LOAD clears done, err and all counters.
- Handshake:
  - s_ready=1 exactly in LOAD and CHK, registered from the state.
  - A byte is consumed only on s_valid && s_ready.
  - s_valid gaps of any length are legal; counters hold through them.
- Stream order:
  - Row 0..7; within each row w1, w2, w3, w4; within each weight LSB first, then MSB.
  - Total 64 payload bytes.
- Write timing:
  - An accepted LSB is held in a byte register.
  - On the accepted MSB, {MSB, LSB} is written to weight[row][k] in the same clock edge.
  - Then k increments. When k wraps from 3 to 0, row increments.
  - Leaving LOAD, row wraps 7 to 0.
- Read port:
  - Combinational from the register array; zero latency, same as the fixed table.
  - During LOAD, reads return a mix of old and new values; consumers must wait for done.
  - An rd_addr value ≥ NEURONS (only possible with a non-power-of-2 NEURONS) returns 0.
- busy = state is LOAD or CHK.
- done asserts on the clock edge that enters DONE.
- Reset mid-load: contents clear to 0 and done stays 0. No partial table survives reset.

Optional Feature:
- Macro: NN_WEIGHT_LOADER_CHECKSUM_EN.
- Defined:
  - Load is 65 bytes; the last byte is XOR of all 64 payload bytes.
  - A running XOR register updates on each accepted payload byte.
  - In CHK, mismatch sets err=1 and done stays 0; match sets done=1.
  - Weights are written either way.
- Undefined:
  - Load is 64 bytes; CHK state, XOR register and err logic are absent.
  - err is tied to 0; done sets after byte 64.

Decomposition:
- Shared package nn_pkg: WIDTH, NEURONS, INPUTS, byte-count constants (64 / 65), and a state enum (IDLE, LOAD, CHK, DONE).
- One natural sub-module, nn_byte_assembler: byte-to-16-bit word assembly plus its lsb/msb phase flag; outputs word and word_valid.
- The top holds the FSM, counters, array and read mux.

Test Plan:
- Full load, no gaps: after start, stream row0 = 28366, 1235, 32767, 28311, with the rest incrementing.
  - First bytes are CE 6E D3 04.
  - After 64 bytes: done=1, busy=0, rd_addr=0 gives w1=28366, w2=1235, w3=32767, w4=28311.
- Negative extremes: weights -32768 (00 80) and -1 (FF FF) at row 5.
  - rd_addr=5 returns -32768 and -1 sign-correct.
- Back-pressure / gaps: random s_valid gaps of 0–7 cycles.
  - Identical final contents to the gap-free run.
  - s_ready=0 in IDLE and DONE, and extra bytes there are not consumed.
- start during load: pulse start after byte 20.
  - Counters unchanged; load completes after byte 64 with correct data.
- Async reset mid-load: assert rst after byte 33, between clock edges.
  - All outputs 0 immediately, busy=0, done=0, rd_addr=0 gives 0.
  - A fresh full load then succeeds.
- Checksum (NN_WEIGHT_LOADER_CHECKSUM_EN):
  - Correct XOR byte gives done=1, err=0.
  - Corrupted XOR byte (correct ^ 0x01) gives done=0, err=1.
  - The next start clears err.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the run-time loadable first-layer
// weight store (nn_weight_loader and its byte assembler).
package nn_pkg;

    localparam int WIDTH   = 16;   // weight width, two bytes per weight
    localparam int NEURONS = 8;    // rows (hidden-layer neurons)
    localparam int INPUTS  = 4;    // weights per row (w1..w4)

    localparam int ADDR_W = $clog2(NEURONS);
    localparam int K_W    = $clog2(INPUTS);

    // 64 payload bytes; one extra checksum byte when the checksum is enabled.
    localparam int PAYLOAD_BYTES = NEURONS * INPUTS * (WIDTH / 8);
    localparam int TOTAL_BYTES   = PAYLOAD_BYTES + 1;
    localparam int CNT_W         = $clog2(TOTAL_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/nn_byte_assembler.sv
// Pairs consecutive accepted bytes (LSB first, then MSB) into one weight word.
// word_valid is asserted combinationally with the accepted MSB so the word can
// be written on that same clock edge.
module nn_byte_assembler
    import nn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [WIDTH-1:0] word,
    output logic             word_valid
);

    logic       phase;   // 0: expecting LSB, 1: expecting MSB
    logic [7:0] lsb;

    // Hold the LSB and toggle the lsb/msb phase on every accepted byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            lsb   <= 8'd0;
        end else if (clear) begin
            phase <= 1'b0;
            lsb   <= 8'd0;
        end else if (byte_valid) begin
            if (!phase) begin
                lsb <= byte_data;
            end
            phase <= ~phase;
        end
    end

    assign word       = {byte_data, lsb};
    assign word_valid = byte_valid && phase;

endmodule

// File: rtl/nn_weight_loader.sv
// Run-time writer for the 8 x 4 first-layer weight array. A start pulse opens
// a load of 64 bytes (row 0..7, w1..w4, LSB then MSB); the array is read
// combinationally through the same rd_addr -> w1..w4 shape as the fixed table.
// Optional feature macro: NN_WEIGHT_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte, a CHK state and the sticky err flag.
// Handshake: a byte moves only on a clock edge where s_valid && s_ready; s_ready
// is high exactly while the FSM is in LOAD or CHK, and s_valid may drop for any
// number of cycles without affecting the counters.
module nn_weight_loader
    import nn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    s_valid,
    input  logic [7:0]              s_data,
    output logic                    s_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic [2:0]              rd_addr,
    output logic signed [WIDTH-1:0] w1,
    output logic signed [WIDTH-1:0] w2,
    output logic signed [WIDTH-1:0] w3,
    output logic signed [WIDTH-1:0] w4
);

    state_t state, state_next;

    logic [CNT_W-1:0]  byte_cnt;
    logic [K_W-1:0]    k;
    logic [ADDR_W-1:0] row;
    logic [WIDTH-1:0]  weights [NEURONS][INPUTS];

    logic             accept;
    logic             pay_accept;
    logic             last_payload;
    logic             load_begin;
    logic             done_set;
    logic [WIDTH-1:0] word;
    logic             word_valid;

    assign accept       = s_valid && s_ready;
    assign pay_accept   = accept && (state == LOAD);
    assign last_payload = pay_accept && (byte_cnt == CNT_W'(PAYLOAD_BYTES - 1));
    assign busy         = (state == LOAD) || (state == CHK);

`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
    logic [7:0] xor_q;
    logic       sum_ok;
    assign sum_ok = (s_data == xor_q);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the load-begin and done-set strobes.
    always_comb begin
        state_next = state;
        load_begin = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = LOAD;
                    load_begin = 1'b1;
                end
            end
            LOAD: begin
                if (last_payload) begin
`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
                    done_set   = 1'b1;
`endif
                end
            end
`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_next = DONE;
                    done_set   = sum_ok;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // s_ready is registered from the upcoming state so it is high exactly in LOAD/CHK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready <= 1'b0;
        end else begin
            s_ready <= (state_next == LOAD) || (state_next == CHK);
        end
    end

    nn_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_begin),
        .byte_valid (pay_accept),
        .byte_data  (s_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Byte, weight-in-row and row counters; row wraps back to 0 after the last row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            k        <= '0;
            row      <= '0;
        end else if (load_begin) begin
            byte_cnt <= '0;
            k        <= '0;
            row      <= '0;
        end else if (pay_accept) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (word_valid) begin
                if (k == K_W'(INPUTS - 1)) begin
                    k   <= '0;
                    row <= (row == ADDR_W'(NEURONS - 1)) ? '0 : row + 1'b1;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end

    // Weight array: cleared by reset, written on every completed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NEURONS; r++) begin
                for (int c = 0; c < INPUTS; c++) begin
                    weights[r][c] <= '0;
                end
            end
        end else if (word_valid) begin
            weights[row][k] <= word;
        end
    end

    // Sticky done: set when DONE is entered after a good load, cleared on the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else if (load_begin) begin
            done <= 1'b0;
        end else if (done_set) begin
            done <= 1'b1;
        end
    end

`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
    // Running XOR of payload bytes and sticky checksum error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_q <= 8'd0;
            err   <= 1'b0;
        end else if (load_begin) begin
            xor_q <= 8'd0;
            err   <= 1'b0;
        end else begin
            if (pay_accept) begin
                xor_q <= xor_q ^ s_data;
            end
            if ((state == CHK) && accept && !sum_ok) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    // Zero-latency read mux; out-of-range rows read as zero.
    always_comb begin
        w1 = '0;
        w2 = '0;
        w3 = '0;
        w4 = '0;
        if (int'(rd_addr) < NEURONS) begin
            w1 = weights[rd_addr][0];
            w2 = weights[rd_addr][1];
            w3 = weights[rd_addr][2];
            w4 = weights[rd_addr][3];
        end
    end

endmodule

// File: tb/tb_nn_weight_loader.sv
// Directed bench for nn_weight_loader: full loads with and without s_valid gaps,
// negative extremes, ignored start during load, async reset mid-load and, when
// NN_WEIGHT_LOADER_CHECKSUM_EN is defined, good and corrupted checksum bytes.
module tb_nn_weight_loader;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               s_valid = 1'b0;
    logic [7:0]         s_data = 8'd0;
    logic               s_ready, busy, done, err;
    logic [2:0]         rd_addr = 3'd0;
    logic signed [15:0] w1, w2, w3, w4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_w [32];
    logic [7:0]  pay   [64];

    nn_weight_loader dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rd_addr (rd_addr),
        .w1      (w1),
        .w2      (w2),
        .w3      (w3),
        .w4      (w4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Row 0 = 28366, 1235, 32767, 28311; later weights keep counting up from 28311.
    // With neg set, row 5 w1/w2 become -32768 and -1.
    function automatic void build(input bit neg);
        exp_w[0] = 16'h6ECE;
        exp_w[1] = 16'h04D3;
        exp_w[2] = 16'h7FFF;
        exp_w[3] = 16'h6E97;
        for (int i = 4; i < 32; i++) exp_w[i] = 16'(28311 + i - 3);
        if (neg) begin
            exp_w[20] = 16'h8000;
            exp_w[21] = 16'hFFFF;
        end
        for (int i = 0; i < 32; i++) begin
            pay[2*i]   = exp_w[i][7:0];
            pay[2*i+1] = exp_w[i][15:8];
        end
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        align();
        start = 1'b0;
    endtask

    // Present one byte after a random gap and hold it until the edge that accepts it.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) align();
        s_valid = 1'b1;
        s_data  = b;
        waited  = 0;
        while (!s_ready && waited < 50) begin
            align();
            waited++;
        end
        check("s_ready wait", {31'b0, s_ready}, 32'd1);
        align();
        s_valid = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < 8; r++) begin
            rd_addr = 3'(r);
            #1;
            check($sformatf("%s r%0d w1", tag, r), {16'b0, w1}, {16'b0, exp_w[4*r]});
            check($sformatf("%s r%0d w2", tag, r), {16'b0, w2}, {16'b0, exp_w[4*r+1]});
            check($sformatf("%s r%0d w3", tag, r), {16'b0, w3}, {16'b0, exp_w[4*r+2]});
            check($sformatf("%s r%0d w4", tag, r), {16'b0, w4}, {16'b0, exp_w[4*r+3]});
        end
        rd_addr = 3'd0;
        align();
    endtask

    // Full load of pay[]; optional start pulse after byte start_after; optional bad checksum.
    task automatic run_load(input int max_gap, input int start_after, input bit bad_sum);
        logic [7:0] x;
        x = 8'd0;
        pulse_start();
        check("load busy", {31'b0, busy}, 32'd1);
        check("load done clr", {31'b0, done}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            send_byte(pay[i], max_gap);
            x = x ^ pay[i];
            if (i + 1 == start_after) begin
                pulse_start();
                check("restart busy", {31'b0, busy}, 32'd1);
                check("restart done", {31'b0, done}, 32'd0);
            end
        end
`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
        check("chk busy", {31'b0, busy}, 32'd1);
        check("chk done", {31'b0, done}, 32'd0);
        send_byte(bad_sum ? (x ^ 8'h01) : x, max_gap);
`else
        if (bad_sum) check("bad_sum unsupported", 32'd1, 32'd0);
`endif
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst s_ready", {31'b0, s_ready}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst err", {31'b0, err}, 32'd0);
        rd_addr = 3'd7;
        #1;
        check("rst r7 w4", {16'b0, w4}, 32'd0);
        rd_addr = 3'd0;
        repeat (2) align();
        rst = 1'b0;
        align();

        // Bytes offered in IDLE are ignored.
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (3) begin
            check("idle s_ready", {31'b0, s_ready}, 32'd0);
            align();
        end
        s_valid = 1'b0;
        check("idle r0 w1", {16'b0, w1}, 32'd0);

        // Negative extremes at row 5, gap-free.
        build(1'b1);
        run_load(0, -1, 1'b0);
        check("neg done", {31'b0, done}, 32'd1);
        check("neg busy", {31'b0, busy}, 32'd0);
        check("neg err", {31'b0, err}, 32'd0);
        rd_addr = 3'd5;
        #1;
        check("neg r5 w1", {16'b0, w1}, 32'h0000_8000);
        check("neg r5 w2", {16'b0, w2}, 32'h0000_FFFF);
        check("neg r5 w1 sign", {31'b0, (w1 < 0)}, 32'd1);
        check("neg r5 w2 val", 32'(w2 == -16'sd1), 32'd1);
        align();
        check_all("neg");

        // Gap-free base pattern.
        build(1'b0);
        run_load(0, -1, 1'b0);
        check("base done", {31'b0, done}, 32'd1);
        check("base busy", {31'b0, busy}, 32'd0);
        check("base s_ready", {31'b0, s_ready}, 32'd0);
        rd_addr = 3'd0;
        #1;
        check("base r0 w1", {16'b0, w1}, 32'd28366);
        check("base r0 w2", {16'b0, w2}, 32'd1235);
        check("base r0 w3", {16'b0, w3}, 32'd32767);
        check("base r0 w4", {16'b0, w4}, 32'd28311);
        align();
        check_all("base");

        // Bytes offered in DONE are ignored.
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (3) begin
            check("done s_ready", {31'b0, s_ready}, 32'd0);
            align();
        end
        s_valid = 1'b0;
        check("done sticky", {31'b0, done}, 32'd1);
        check("done r0 w1", {16'b0, w1}, 32'd28366);

        // Neg pattern with random gaps and a start pulse after byte 20.
        build(1'b1);
        run_load(7, 20, 1'b0);
        check("gap done", {31'b0, done}, 32'd1);
        check("gap busy", {31'b0, busy}, 32'd0);
        check_all("gap");

        // Async reset between edges after byte 33 of a base-pattern load.
        build(1'b0);
        pulse_start();
        for (int i = 0; i < 33; i++) send_byte(pay[i], 0);
        #3;
        rst = 1'b1;
        #1;
        check("mid rst busy", {31'b0, busy}, 32'd0);
        check("mid rst done", {31'b0, done}, 32'd0);
        check("mid rst s_ready", {31'b0, s_ready}, 32'd0);
        check("mid rst r0 w1", {16'b0, w1}, 32'd0);
        rd_addr = 3'd5;
        #1;
        check("mid rst r5 w2", {16'b0, w2}, 32'd0);
        rd_addr = 3'd0;
        align();
        rst = 1'b0;
        align();
        run_load(3, -1, 1'b0);
        check("fresh done", {31'b0, done}, 32'd1);
        check_all("fresh");

`ifdef NN_WEIGHT_LOADER_CHECKSUM_EN
        // Corrupted checksum: weights written, err set, done low; next start clears err.
        build(1'b1);
        run_load(0, -1, 1'b1);
        check("badsum done", {31'b0, done}, 32'd0);
        check("badsum err", {31'b0, err}, 32'd1);
        check("badsum busy", {31'b0, busy}, 32'd0);
        check_all("badsum");
        pulse_start();
        check("restart err clr", {31'b0, err}, 32'd0);
        check("restart busy2", {31'b0, busy}, 32'd1);
        build(1'b0);
        for (int i = 0; i < 64; i++) send_byte(pay[i], 0);
        begin
            logic [7:0] x;
            x = 8'd0;
            for (int i = 0; i < 64; i++) x = x ^ pay[i];
            send_byte(x, 0);
        end
        check("goodsum done", {31'b0, done}, 32'd1);
        check("goodsum err", {31'b0, err}, 32'd0);
        check_all("goodsum");
`else
        check("no-chk err", {31'b0, err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
